// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Instruction-fetch controller for a 2K x 14-bit PIC16-style program ROM.
// Owns the program counter, drives the ROM address and latches each fetched
// word into a one-deep instruction register (IR) for the execute stage.
// GOTO, CALL, RETURN and RETLW are sequenced here. CALL, RETURN and RETLW use
// a circular hardware return stack. Skip and computed-branch requests from
// the execute stage are accepted. Every pipeline bubble is created in this
// block.
//
// Ports
//   clk            in   rising-edge system clock
//   reset          in   asynchronous, active-high reset
//   Rom_addr       out  ROM address (combinational copy of the PC register)
//   Rom_data       in   ROM read data for Rom_addr, valid in the same cycle
//   stall          in   freeze every register this cycle
//   skip_req       in   discard the word currently being fetched
//   branch_req     in   redirect fetch to branch_target
//   branch_target  in   redirect address, used only with branch_req
//   ir             out  latched instruction word
//   ir_addr        out  address of the word held in ir
//   ir_valid       out  ir holds an instruction to execute (0 = bubble)
//   stack_ovf      out  sticky: push while the return stack was full
//   stack_unf      out  sticky: pop while the return stack was empty
// ----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int ADDR_W      = 11,
  parameter int INSTR_W     = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  Rom_addr,
  input  logic [INSTR_W-1:0] Rom_data,
  input  logic               stall,
  input  logic               skip_req,
  input  logic               branch_req,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_addr,
  output logic               ir_valid,
  output logic               stack_ovf,
  output logic               stack_unf
);

  // Stack pointer width. STACK_DEPTH is a power of two, so the pointer wraps
  // naturally. The occupancy counter needs one extra bit to hold the value
  // STACK_DEPTH itself.
  localparam int SP_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int DEPTH_W = SP_W + 1;

  localparam logic [DEPTH_W-1:0] DEPTH_FULL  = DEPTH_W'(STACK_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_EMPTY = {DEPTH_W{1'b0}};
  localparam logic [INSTR_W-1:0] OP_RETURN   = INSTR_W'(14'h0008);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0]  pc_q,       pc_d;
  logic [INSTR_W-1:0] ir_q,       ir_d;
  logic [ADDR_W-1:0]  ir_addr_q,  ir_addr_d;
  logic               ir_valid_q, ir_valid_d;

  logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
  logic [SP_W-1:0]    sp_q;
  logic [DEPTH_W-1:0] depth_q;
  logic               ovf_q;
  logic               unf_q;

  // --------------------------------------------------------------------------
  // Decode of the word in IR. A bubble in IR never decodes as an operation.
  // --------------------------------------------------------------------------
  logic               is_goto;
  logic               is_call;
  logic               is_ret;
  logic               is_retlw;
  logic               is_ctl_op;
  logic [ADDR_W-1:0]  jump_target;
  logic [SP_W-1:0]    sp_top;
  logic [ADDR_W-1:0]  stack_top;
  logic [ADDR_W-1:0]  return_addr;

  // Opcode matching on the registered instruction word.
  always_comb begin
    is_goto   = ir_valid_q && (ir_q[13:11] == 3'b101);
    is_call   = ir_valid_q && (ir_q[13:11] == 3'b100);
    is_ret    = ir_valid_q && (ir_q == OP_RETURN);
    is_retlw  = ir_valid_q && (ir_q[13:10] == 4'b1101);
    is_ctl_op = is_goto || is_call || is_ret || is_retlw;
  end

  // The GOTO/CALL literal is the low 11 bits of IR. The return address is the
  // word following the CALL. A pop reads the slot just below the pointer.
  assign jump_target = ADDR_W'(ir_q[10:0]);
  assign return_addr = ir_addr_q + ADDR_W'(1);
  assign sp_top      = sp_q - SP_W'(1);
  assign stack_top   = stack_q[sp_top];

  // --------------------------------------------------------------------------
  // Next-state selection. Priority below stall: internal op, branch, skip,
  // then normal fetch. External requests count only when IR is valid and IR
  // is not an internal op, because the internal op takes precedence.
  // --------------------------------------------------------------------------
  logic do_push;
  logic do_pop;

  // Fetch pipeline next-state and stack push/pop strobes.
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_addr_d  = ir_addr_q;
    ir_valid_d = ir_valid_q;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    if (!stall) begin
      // IR always captures the word being fetched. Redirects only mark the
      // captured word invalid.
      ir_d       = Rom_data;
      ir_addr_d  = pc_q;
      ir_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(1);
      if (is_goto) begin
        pc_d       = jump_target;
        ir_valid_d = 1'b0;
      end else if (is_call) begin
        pc_d       = jump_target;
        ir_valid_d = 1'b0;
        do_push    = 1'b1;
      end else if (is_ret || is_retlw) begin
        pc_d       = stack_top;
        ir_valid_d = 1'b0;
        do_pop     = 1'b1;
      end else if (ir_valid_q && branch_req) begin
        pc_d       = branch_target;
        ir_valid_d = 1'b0;
      end else if (ir_valid_q && skip_req) begin
        // The PC still advances. Only the word fetched now is dropped.
        ir_valid_d = 1'b0;
      end else begin
        ir_valid_d = 1'b1;
      end
    end else begin
      ir_valid_d = ir_valid_q;
    end
  end

  // Pipeline registers: PC, IR, IR address and IR valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= {ADDR_W{1'b0}};
      ir_q       <= {INSTR_W{1'b0}};
      ir_addr_q  <= {ADDR_W{1'b0}};
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_addr_q  <= ir_addr_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Return stack. The stack is circular: on overflow the write lands on the
  // oldest slot, because the pointer has wrapped onto it. On underflow the
  // pop returns whatever the wrapped slot holds. The occupancy counter
  // saturates at both ends, and the sticky flags record each event.
  // --------------------------------------------------------------------------
  logic [SP_W-1:0]    sp_d;
  logic [DEPTH_W-1:0] depth_d;
  logic               ovf_d;
  logic               unf_d;

  // Stack pointer, occupancy counter and sticky flag next-state.
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (do_push) begin
      sp_d = sp_q + SP_W'(1);
      if (depth_q == DEPTH_FULL) begin
        ovf_d = 1'b1;
      end else begin
        depth_d = depth_q + DEPTH_W'(1);
      end
    end else if (do_pop) begin
      sp_d = sp_top;
      if (depth_q == DEPTH_EMPTY) begin
        unf_d = 1'b1;
      end else begin
        depth_d = depth_q - DEPTH_W'(1);
      end
    end else begin
      sp_d = sp_q;
    end
  end

  // Stack storage and bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_q[i] <= {ADDR_W{1'b0}};
      end
      sp_q    <= {SP_W{1'b0}};
      depth_q <= DEPTH_EMPTY;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (do_push) begin
        stack_q[sp_q] <= return_addr;
      end
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Rom_addr depends only on the PC register, so there is no
  // combinational path from Rom_data back to the address.
  // --------------------------------------------------------------------------
  assign Rom_addr  = pc_q;
  assign ir        = ir_q;
  assign ir_addr   = ir_addr_q;
  assign ir_valid  = ir_valid_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed bench for fetch_sequencer. A behavioural ROM answers Rom_addr in
// the same cycle. Inputs change and outputs are sampled 1 time unit after
// each rising edge. Expected values are hand-computed from the program
// placed in the ROM.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [10:0] Rom_addr;
  logic [13:0] Rom_data;
  logic        stall;
  logic        skip_req;
  logic        branch_req;
  logic [10:0] branch_target;
  logic [13:0] ir;
  logic [10:0] ir_addr;
  logic        ir_valid;
  logic        stack_ovf;
  logic        stack_unf;

  logic [13:0] rom [0:2047];

  int tests_run;
  int tests_failed;

  fetch_sequencer #(
    .ADDR_W      (11),
    .INSTR_W     (14),
    .STACK_DEPTH (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Rom_addr      (Rom_addr),
    .Rom_data      (Rom_data),
    .stall         (stall),
    .skip_req      (skip_req),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .ir            (ir),
    .ir_addr       (ir_addr),
    .ir_valid      (ir_valid),
    .stack_ovf     (stack_ovf),
    .stack_unf     (stack_unf)
  );

  assign Rom_data = rom[Rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  // Reset across one edge. The release happens 1 unit after that edge.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int a;
    int r;
    int t;
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    stall         = 1'b0;
    skip_req      = 1'b0;
    branch_req    = 1'b0;
    branch_target = 11'h000;
    rom_clear();

    // ---- Test 1: reset state and straight-line fetch ----
    rom[0] = 14'h01A1; rom[1] = 14'h01A2; rom[2] = 14'h303C; rom[3] = 14'h00A3;
    #2;
    check("rst_rom_addr", Rom_addr, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_ir_addr", ir_addr, 32'h0);
    check("rst_ir_valid", ir_valid, 32'h0);
    check("rst_ovf", stack_ovf, 32'h0);
    check("rst_unf", stack_unf, 32'h0);
    tick();
    reset = 1'b0;
    check("t1_rom_addr0", Rom_addr, 32'h0);
    tick();
    check("t1_ir0", ir, 32'h01A1); check("t1_ia0", ir_addr, 32'h0);
    check("t1_v0", ir_valid, 32'h1); check("t1_ra1", Rom_addr, 32'h1);
    tick();
    check("t1_ir1", ir, 32'h01A2); check("t1_ia1", ir_addr, 32'h1);
    check("t1_ra2", Rom_addr, 32'h2);
    tick();
    check("t1_ir2", ir, 32'h303C); check("t1_ia2", ir_addr, 32'h2);
    check("t1_ra3", Rom_addr, 32'h3);
    tick();
    check("t1_ir3", ir, 32'h00A3); check("t1_ia3", ir_addr, 32'h3);
    check("t1_v3", ir_valid, 32'h1); check("t1_ra4", Rom_addr, 32'h4);

    // ---- Test 2: GOTO 0x005 at 0x010 ----
    rom[11'h010] = 14'h2805; rom[11'h005] = 14'h0155;
    apply_reset();
    repeat (17) tick();
    check("t2_goto_ir", ir, 32'h2805); check("t2_goto_ia", ir_addr, 32'h010);
    check("t2_goto_v", ir_valid, 32'h1);
    tick();
    check("t2_bubble_v", ir_valid, 32'h0); check("t2_bubble_ra", Rom_addr, 32'h005);
    check("t2_bubble_ia", ir_addr, 32'h011);
    tick();
    check("t2_tgt_ir", ir, 32'h0155); check("t2_tgt_ia", ir_addr, 32'h005);
    check("t2_tgt_v", ir_valid, 32'h1);
    check("t2_ovf", stack_ovf, 32'h0); check("t2_unf", stack_unf, 32'h0);

    // ---- Test 3: CALL 0x020 at 0x003, RETURN at 0x020 ----
    rom[3] = 14'h2020; rom[11'h020] = 14'h0008; rom[4] = 14'h0AB4;
    apply_reset();
    repeat (4) tick();
    check("t3_call_ir", ir, 32'h2020); check("t3_call_ia", ir_addr, 32'h003);
    // A branch request loses to the CALL in IR.
    branch_req = 1'b1; branch_target = 11'h300;
    tick();
    branch_req = 1'b0;
    check("t3_call_bub_v", ir_valid, 32'h0); check("t3_call_ra", Rom_addr, 32'h020);
    tick();
    check("t3_ret_ir", ir, 32'h0008); check("t3_ret_ia", ir_addr, 32'h020);
    check("t3_ret_v", ir_valid, 32'h1);
    tick();
    check("t3_ret_bub_v", ir_valid, 32'h0); check("t3_ret_ra", Rom_addr, 32'h004);
    tick();
    check("t3_back_ir", ir, 32'h0AB4); check("t3_back_ia", ir_addr, 32'h004);
    check("t3_back_v", ir_valid, 32'h1); check("t3_back_ra", Rom_addr, 32'h005);
    check("t3_ovf", stack_ovf, 32'h0); check("t3_unf", stack_unf, 32'h0);

    // ---- Test 4: nine nested CALLs then nine RETURNs ----
    rom_clear();
    rom[0] = 14'h2900;                                // GOTO 0x100
    for (int i = 0; i < 9; i++) begin
      a = 'h100 + 16 * i;
      rom[a] = 14'h2000 | 14'(a + 16);                // CALL next level
    end
    rom[11'h190] = 14'h0008;
    for (int k = 0; k < 8; k++) rom[11'h111 + 11'(16 * k)] = 14'h0008;
    apply_reset();
    tick();
    check("t4_goto_ir", ir, 32'h2900);
    tick();
    check("t4_goto_ra", Rom_addr, 32'h100);
    for (int i = 0; i < 9; i++) begin
      a = 'h100 + 16 * i;
      tick();
      check("t4_call_v", ir_valid, 32'h1); check("t4_call_ia", ir_addr, a);
      tick();
      check("t4_call_bub_v", ir_valid, 32'h0); check("t4_call_ra", Rom_addr, a + 16);
      check("t4_ovf", stack_ovf, (i == 8) ? 32'h1 : 32'h0);
    end
    for (int j = 0; j < 9; j++) begin
      r = (j == 0) ? 'h190 : ('h191 - 16 * j);
      t = (j == 8) ? 'h181 : ('h181 - 16 * j);
      tick();
      check("t4_ret_v", ir_valid, 32'h1); check("t4_ret_ia", ir_addr, r);
      check("t4_ret_ir", ir, 32'h0008);
      tick();
      check("t4_ret_bub_v", ir_valid, 32'h0); check("t4_ret_ra", Rom_addr, t);
      check("t4_unf", stack_unf, (j == 8) ? 32'h1 : 32'h0);
      check("t4_ovf_sticky", stack_ovf, 32'h1);
    end

    // ---- Test 5: skip, branch, request ignored in a bubble, PC wrap ----
    rom_clear();
    apply_reset();
    repeat (9) tick();
    check("t5_ia8", ir_addr, 32'h008); check("t5_v8", ir_valid, 32'h1);
    skip_req = 1'b1;
    tick();
    skip_req = 1'b0;
    check("t5_skip_ia", ir_addr, 32'h009); check("t5_skip_v", ir_valid, 32'h0);
    check("t5_skip_ra", Rom_addr, 32'h00A);
    tick();
    check("t5_after_skip_ia", ir_addr, 32'h00A); check("t5_after_skip_v", ir_valid, 32'h1);
    repeat (22) tick();
    check("t5_ia20", ir_addr, 32'h020); check("t5_v20", ir_valid, 32'h1);
    branch_req = 1'b1; branch_target = 11'h00A;
    tick();
    check("t5_br_v", ir_valid, 32'h0); check("t5_br_ra", Rom_addr, 32'h00A);
    check("t5_br_ia", ir_addr, 32'h021);
    branch_target = 11'h300;                           // held request, IR is a bubble
    tick();
    check("t5_br_tgt_ia", ir_addr, 32'h00A); check("t5_br_tgt_v", ir_valid, 32'h1);
    check("t5_br_ign_ra", Rom_addr, 32'h00B);
    branch_target = 11'h7FE;
    tick();
    branch_req = 1'b0;
    check("t5_wrap_ra", Rom_addr, 32'h7FE);
    tick();
    check("t5_wrap_ia7fe", ir_addr, 32'h7FE); check("t5_wrap_ra7ff", Rom_addr, 32'h7FF);
    tick();
    check("t5_wrap_ia7ff", ir_addr, 32'h7FF); check("t5_wrap_ra0", Rom_addr, 32'h000);
    tick();
    check("t5_wrap_ia0", ir_addr, 32'h000); check("t5_wrap_v0", ir_valid, 32'h1);

    // ---- Test 6: stall, then asynchronous reset after a CALL push ----
    rom_clear();
    rom[3] = 14'h2020; rom[11'h040] = 14'h0008; rom[1] = 14'h0111;
    apply_reset();
    repeat (2) tick();
    check("t6_pre_ia", ir_addr, 32'h001); check("t6_pre_ra", Rom_addr, 32'h002);
    stall = 1'b1; branch_req = 1'b1; branch_target = 11'h300; skip_req = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      check("t6_stall_ia", ir_addr, 32'h001); check("t6_stall_ir", ir, 32'h0111);
      check("t6_stall_v", ir_valid, 32'h1); check("t6_stall_ra", Rom_addr, 32'h002);
    end
    stall = 1'b0; branch_req = 1'b0; skip_req = 1'b0;
    tick();
    check("t6_resume_ia", ir_addr, 32'h002); check("t6_resume_v", ir_valid, 32'h1);
    check("t6_resume_ra", Rom_addr, 32'h003);
    tick();
    check("t6_call_ir", ir, 32'h2020);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("t6_call_stall_ra", Rom_addr, 32'h004); check("t6_call_stall_v", ir_valid, 32'h1);
    tick();
    check("t6_call_bub_ra", Rom_addr, 32'h020); check("t6_call_bub_v", ir_valid, 32'h0);
    reset = 1'b1;
    #2;
    check("t6_arst_ra", Rom_addr, 32'h000); check("t6_arst_v", ir_valid, 32'h0);
    check("t6_arst_ir", ir, 32'h0); check("t6_arst_ia", ir_addr, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_post_ia", ir_addr, 32'h000); check("t6_post_v", ir_valid, 32'h1);
    branch_req = 1'b1; branch_target = 11'h040;
    tick();
    branch_req = 1'b0;
    check("t6_br_ra", Rom_addr, 32'h040);
    tick();
    check("t6_ret_ir", ir, 32'h0008); check("t6_ret_unf0", stack_unf, 32'h0);
    tick();
    // The stack was emptied by reset, so this pop underflows.
    check("t6_ret_unf1", stack_unf, 32'h1); check("t6_ret_v", ir_valid, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
